// File: rtl/f2fx_share_arbiter.sv
// f2fx_share_arbiter
//   Round-robin arbiter/sequencer that shares one float-to-fixed converter
//   (Begin/ACK handshake) among N requesters. Latches the winner's operand,
//   holds the converter's begin level, captures the result, pulses a
//   per-requester done, and aborts/resets the converter after a timeout.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req[N]       per-requester request level, held until done
//   i_float_in     N packed 32-bit operands, requester i at [32i+31:32i]
//   o_gnt[N]       one-hot registered grant
//   o_done[N]      one-cycle completion pulse to the granted requester
//   o_err[N]       one-cycle pulse with o_done on abort only
//   o_result       fixed-point result of the last successful conversion
//   o_busy         high in every state except IDLE
//   o_conv_f       registered operand to the converter
//   o_conv_begin   converter start level
//   i_conv_ack     converter done indication
//   i_conv_result  converter output, valid while i_conv_ack=1
//   o_conv_rst     active-high converter reset during abort
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no operation; arbitrate pending requests from r_ptr
// S_LOAD    | grant and operand registered; raise begin next
// S_WAIT    | begin held, timeout counter running, waiting for ack
// S_RELEASE | result captured; wait for converter to drop ack
// S_ABORT   | converter held in reset for RST_CYC cycles

module f2fx_share_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int RST_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N-1:0]      i_req,
    input  logic [32*N-1:0]   i_float_in,
    output logic [N-1:0]      o_gnt,
    output logic [N-1:0]      o_done,
    output logic [N-1:0]      o_err,
    output logic [31:0]       o_result,
    output logic              o_busy,
    output logic [31:0]       o_conv_f,
    output logic              o_conv_begin,
    input  logic              i_conv_ack,
    input  logic [31:0]       i_conv_result,
    output logic              o_conv_rst
);

    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);
    localparam logic [N-1:0]     ONE_HOT0 = N'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    state_t             r_state, w_state;
    logic [SEL_W-1:0]   r_sel, w_sel;
    logic [SEL_W-1:0]   r_ptr, w_ptr;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [RC_W-1:0]    r_rc, w_rc;
    logic [N-1:0]       r_gnt, w_gnt;
    logic [N-1:0]       r_done, w_done;
    logic [N-1:0]       r_err, w_err;
    logic [31:0]        r_result, w_result;
    logic [31:0]        r_conv_f, w_conv_f;
    logic               r_conv_begin, w_conv_begin;
    logic               r_conv_rst, w_conv_rst;

    // Round-robin pick: rotate requests so r_ptr sits at bit 0, find the
    // lowest set bit, then rotate the offset back (mod N, N need not be 2^k).
    logic [2*N-1:0]     w_req2;
    logic [N-1:0]       w_rot;
    logic [SEL_W-1:0]   w_off;
    logic [SEL_W:0]     w_sum;
    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_ptr_inc;

    always_comb begin
        w_req2 = {i_req, i_req};
        w_rot  = w_req2[r_ptr +: N];
        w_off  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = SEL_W'(j);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= N_EXT) begin
            w_sum = w_sum - N_EXT;
        end
        w_win     = w_sum[SEL_W-1:0];
        w_ptr_inc = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
    end

    always_comb begin
        w_state      = r_state;
        w_sel        = r_sel;
        w_ptr        = r_ptr;
        w_cnt        = r_cnt;
        w_rc         = r_rc;
        w_gnt        = r_gnt;
        w_done       = '0;
        w_err        = '0;
        w_result     = r_result;
        w_conv_f     = r_conv_f;
        w_conv_begin = r_conv_begin;
        w_conv_rst   = r_conv_rst;

        case (r_state)
            S_IDLE: begin
                // Stale ack is ignored here: only i_req is looked at.
                if (|i_req) begin
                    w_sel    = w_win;
                    w_gnt    = ONE_HOT0 << w_win;
                    w_conv_f = i_float_in[{w_win, 5'b0} +: 32];
                    w_state  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_conv_begin = 1'b1;
                w_cnt        = '0;
                w_state      = S_WAIT;
            end
            S_WAIT: begin
                if (i_conv_ack) begin
                    w_result     = i_conv_result;
                    w_done       = r_gnt;
                    w_conv_begin = 1'b0;
                    w_ptr        = w_ptr_inc;
                    w_state      = S_RELEASE;
                end else if (r_cnt == CNT_LAST) begin
                    w_done       = r_gnt;
                    w_err        = r_gnt;
                    w_conv_begin = 1'b0;
                    w_conv_rst   = 1'b1;
                    w_rc         = '0;
                    w_ptr        = w_ptr_inc;
                    w_state      = S_ABORT;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                w_gnt = '0;
                if (!i_conv_ack) begin
                    w_state = S_IDLE;
                end
            end
            S_ABORT: begin
                if (r_rc == RC_LAST) begin
                    w_conv_rst = 1'b0;
                    w_gnt      = '0;
                    w_state    = S_IDLE;
                end else begin
                    w_rc = r_rc + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_rc         <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_result     <= '0;
            r_conv_f     <= '0;
            r_conv_begin <= 1'b0;
            r_conv_rst   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_sel        <= w_sel;
            r_ptr        <= w_ptr;
            r_cnt        <= w_cnt;
            r_rc         <= w_rc;
            r_gnt        <= w_gnt;
            r_done       <= w_done;
            r_err        <= w_err;
            r_result     <= w_result;
            r_conv_f     <= w_conv_f;
            r_conv_begin <= w_conv_begin;
            r_conv_rst   <= w_conv_rst;
        end
    end

    assign o_gnt        = r_gnt;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_result     = r_result;
    assign o_busy       = (r_state != S_IDLE);
    assign o_conv_f     = r_conv_f;
    assign o_conv_begin = r_conv_begin;
    assign o_conv_rst   = r_conv_rst;

endmodule

// File: tb/tb_f2fx_share_arbiter.sv
// Testbench for f2fx_share_arbiter: converter model plus a scoreboard of
// expected completions (requester, error flag, operand) checked on each done.

module tb_f2fx_share_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int RST_CYC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] float_in;
    logic [N-1:0]    gnt, done, err;
    logic [31:0]     result, conv_f;
    logic            busy, conv_begin, conv_rst;
    logic            conv_ack = 1'b0;
    logic [31:0]     conv_result = 32'h0;

    always #5 clk = ~clk;

    f2fx_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_float_in    (float_in),
        .o_gnt         (gnt),
        .o_done        (done),
        .o_err         (err),
        .o_result      (result),
        .o_busy        (busy),
        .o_conv_f      (conv_f),
        .o_conv_begin  (conv_begin),
        .i_conv_ack    (conv_ack),
        .i_conv_result (conv_result),
        .o_conv_rst    (conv_rst)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Single precision to Q16.16, truncating toward zero in magnitude.
    function automatic logic [31:0] f2fx(input logic [31:0] f);
        int          sh;
        logic [31:0] mag;
        if (f[30:23] == 8'd0) return 32'h0;
        sh  = int'(f[30:23]) - 134;
        mag = {8'b0, 1'b1, f[22:0]};
        if (sh >= 0) mag = mag << sh;
        else         mag = mag >> (-sh);
        return f[31] ? (~mag + 32'd1) : mag;
    endfunction

    // Converter model: ack after lat cycles of begin, hold ack extra_hold
    // cycles after begin drops, never ack when never_ack is set.
    int lat        = 5;
    int extra_hold = 0;
    bit never_ack  = 1'b0;
    int m_cnt      = 0;
    int m_hold     = 0;

    always @(negedge clk) begin
        if (!rst_n || conv_rst) begin
            conv_ack = 1'b0;
            m_cnt    = 0;
        end else if (conv_ack) begin
            if (!conv_begin) begin
                if (m_hold > 0) m_hold--;
                else            conv_ack = 1'b0;
            end
        end else if (conv_begin && !never_ack) begin
            m_cnt++;
            if (m_cnt >= lat) begin
                conv_ack    = 1'b1;
                conv_result = f2fx(conv_f);
                m_cnt       = 0;
                m_hold      = extra_hold;
            end
        end else begin
            m_cnt = 0;
        end
    end

    typedef struct {
        int          idx;
        bit          e;
        logic [31:0] f;
    } sb_t;

    sb_t         sb[$];
    sb_t         sb_e;
    logic [31:0] exp_res = 32'h0;
    logic [N-1:0] prev_done = '0;

    task automatic push(input int idx, input bit e);
        sb_t s;
        s.idx = idx;
        s.e   = e;
        s.f   = float_in[32*idx +: 32];
        sb.push_back(s);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            exp_res   = 32'h0;
            prev_done = '0;
        end else begin
            if (done != '0) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", done, 0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("sb_done_idx", done, 32'(1) << sb_e.idx);
                    chk("sb_err", err, sb_e.e ? (32'(1) << sb_e.idx) : 32'h0);
                    if (!sb_e.e) exp_res = f2fx(sb_e.f);
                    chk("sb_result", result, exp_res);
                end
            end else if (err != '0) begin
                chk("err_without_done", err, 0);
            end
            if (prev_done != '0) chk("done_one_cycle", done, 0);
            if (busy) chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_req(input logic [N-1:0] r);
        @(negedge clk);
        req = r;
    endtask

    task automatic wait_done(input int idx);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < 300);
        chk("done_seen", done, 32'(1) << idx);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic wait_begin();
        int n;
        n = 0;
        while (!conv_begin && n < 300) begin
            tick();
            n++;
        end
        chk("begin_seen", conv_begin, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int order[5];
    int n;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        float_in = {32'h3E800000, 32'hC0400000, 32'h40200000, 32'h3FC00000};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conv_f", conv_f, 0);
        chk("rst_begin", conv_begin, 0);
        chk("rst_conv_rst", conv_rst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single request, converter latency 5
        lat = 5;
        push(0, 1'b0);
        drv_req(4'b0001);
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_conv_f", conv_f, 32'h3FC00000);
        chk("t1_busy", busy, 1);
        chk("t1_begin_e0", conv_begin, 0);
        tick();
        chk("t1_begin_e1", conv_begin, 1);
        repeat (4) tick();
        chk("t1_no_early_done", done, 0);
        tick();
        chk("t1_done", done, 4'b0001);
        chk("t1_result", result, 32'h00018000);
        @(negedge clk);
        req = '0;
        tick();
        chk("t1_busy_after", busy, 0);
        chk("t1_gnt_after", gnt, 0);

        // Simultaneous requests from PTR=0
        do_reset();
        lat   = 3;
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) push(order[k], 1'b0);
        drv_req(4'b1111);
        for (int k = 0; k < 5; k++) wait_done(order[k]);
        @(negedge clk);
        req = '0;
        wait_idle();

        // Timeout on requester 1, then requester 2 granted
        never_ack = 1'b1;
        push(1, 1'b1);
        push(2, 1'b0);
        drv_req(4'b0110);
        tick();
        chk("t3_gnt", gnt, 4'b0010);
        tick();
        chk("t3_begin", conv_begin, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < 200);
        chk("t3_abort_latency", n, TIMEOUT);
        chk("t3_err", err, 4'b0010);
        chk("t3_conv_rst_1", conv_rst, 1);
        chk("t3_begin_low", conv_begin, 0);
        chk("t3_result_kept", result, 32'h00018000);
        @(negedge clk);
        req       = 4'b0100;
        never_ack = 1'b0;
        lat       = 3;
        tick();
        chk("t3_conv_rst_2", conv_rst, 1);
        chk("t3_done_once", done, 0);
        tick();
        chk("t3_conv_rst_off", conv_rst, 0);
        chk("t3_busy_off", busy, 0);
        tick();
        chk("t3_next_gnt", gnt, 4'b0100);
        wait_done(2);
        @(negedge clk);
        req = '0;
        wait_idle();

        // Asynchronous reset during WAIT
        lat = 20;
        drv_req(4'b0100);
        tick();
        chk("t4_gnt", gnt, 4'b0100);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1100;
        #1;
        chk("t4_gnt_clr", gnt, 0);
        chk("t4_begin_clr", conv_begin, 0);
        chk("t4_busy_clr", busy, 0);
        chk("t4_result_clr", result, 0);
        chk("t4_conv_rst", conv_rst, 0);
        chk("t4_conv_f_clr", conv_f, 0);
        @(negedge clk);
        @(negedge clk);
        lat = 3;
        push(2, 1'b0);
        push(3, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("t4_regrant_ptr0", gnt, 4'b0100);
        wait_done(2);
        @(negedge clk);
        req = 4'b1000;
        wait_done(3);
        @(negedge clk);
        req = '0;
        wait_idle();

        // Withdrawal during WAIT and ack held 3 extra cycles
        lat = 2;
        push(1, 1'b0);
        drv_req(4'b0010);
        wait_done(1);
        @(negedge clk);
        req = '0;
        wait_idle();
        lat        = 4;
        extra_hold = 3;
        push(2, 1'b0);
        push(1, 1'b0);
        drv_req(4'b0110);
        tick();
        chk("t5_gnt", gnt, 4'b0100);
        tick();
        chk("t5_begin", conv_begin, 1);
        @(negedge clk);
        req = 4'b0010;
        wait_done(2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_hold_busy", busy, 1);
            chk("t5_hold_gnt", gnt, 0);
        end
        tick();
        chk("t5_release_exit", busy, 0);
        tick();
        chk("t5_gnt_next", gnt, 4'b0010);
        extra_hold = 0;
        wait_done(1);
        @(negedge clk);
        req = '0;
        wait_idle();

        // Fairness: REQ[0] held, REQ[3] raised once
        lat = 3;
        push(0, 1'b0);
        push(3, 1'b0);
        push(0, 1'b0);
        drv_req(4'b0001);
        wait_begin();
        @(negedge clk);
        req = 4'b1001;
        wait_done(0);
        wait_done(3);
        @(negedge clk);
        req = 4'b0001;
        wait_done(0);
        @(negedge clk);
        req = '0;
        wait_idle();

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
